// File: rtl/prop_check_sched.sv
// Time-sliced toggle-implication checker: drives a toggling stimulus, arms one attempt per
// cycle in round-robin slots, and reports failures over a shared round-robin valid/ready channel.

module prop_check_slot #(
  parameter int CYC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             set,
  input  logic             clr,
  input  logic [CYC_W-1:0] ncyc,
  output logic             flag,
  output logic [CYC_W-1:0] fcyc
);
  // A failure arriving while this slot is being accepted re-arms it with the new cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      flag <= 1'b0;
      fcyc <= '0;
    end else if (set && (!flag || clr)) begin
      flag <= 1'b1;
      fcyc <= ncyc;
    end else if (clr) begin
      flag <= 1'b0;
    end
  end
endmodule

module prop_check_sched #(
  parameter  int NUM_CHK = 2,
  parameter  int MAX_CYC = 11,
  parameter  int CYC_W   = 32,
  parameter  int CNT_W   = 8,
  localparam int ID_W    = $clog2(NUM_CHK)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NUM_CHK-1:0] chk_en,
  input  logic               inject_err,
  output logic               val,
  output logic [CYC_W-1:0]   cyc,
  output logic               busy,
  output logic               done,
  output logic               fail_valid,
  input  logic               fail_ready,
  output logic [ID_W-1:0]    fail_id,
  output logic [CYC_W-1:0]   fail_cyc,
  output logic [CNT_W-1:0]   pass_cnt,
  output logic [CNT_W-1:0]   fail_cnt,
  output logic [CNT_W-1:0]   ovf_cnt,
  output logic               stop_req
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [CYC_W-1:0] cyc;
    logic             val;
  } att_t;

  state_t                        state;
  att_t                          att_q;
  logic                          att_v, arm, launch;
  logic                          ev_pass, ev_fail, ovf_ev, acc, hit;
  logic [ID_W-1:0]               slot, rr, rr_gnt, gnt_id, lock_id, idx;
  logic                          lock_v;
  logic [NUM_CHK-1:0]            flags, set_v, clr_v;
  logic [NUM_CHK-1:0][CYC_W-1:0] fcyc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign launch     = (state == S_IDLE || state == S_DONE) && start;
  assign arm        = (state == S_RUN) && (cyc < CYC_W'(MAX_CYC)) && chk_en[slot];
  assign ev_pass    = att_v && (val != att_q.val);
  assign ev_fail    = att_v && (val == att_q.val);
  assign fail_valid = |flags;
  assign acc        = fail_valid && fail_ready;
  assign ovf_ev     = ev_fail && flags[att_q.id] && !clr_v[att_q.id];

  // Once presented, a grant is locked until accepted so id/cyc cannot shift under a stall.
  assign gnt_id   = lock_v ? lock_id : rr_gnt;
  assign fail_id  = gnt_id;
  assign fail_cyc = fcyc[gnt_id];

  assign busy     = (state == S_RUN) || (state == S_DRAIN);
  assign done     = (state == S_DONE);
  assign stop_req = done && (fail_cnt != '0);

  always_comb begin
    rr_gnt = rr;
    hit    = 1'b0;
    idx    = '0;
    for (int i = 0; i < NUM_CHK; i++) begin
      idx = ID_W'((int'(rr) + i) % NUM_CHK);
      if (!hit && flags[idx]) begin
        hit    = 1'b1;
        rr_gnt = idx;
      end
    end
  end

  for (genvar k = 0; k < NUM_CHK; k++) begin : g_chk
    assign set_v[k] = ev_fail && (att_q.id == ID_W'(k));
    assign clr_v[k] = acc && (gnt_id == ID_W'(k));
    prop_check_slot #(.CYC_W(CYC_W)) u_slot (
      .clk  (clk),
      .rst  (rst),
      .clear(launch),
      .set  (set_v[k]),
      .clr  (clr_v[k]),
      .ncyc (att_q.cyc),
      .flag (flags[k]),
      .fcyc (fcyc[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cyc      <= '0;
      val      <= 1'b0;
      slot     <= '0;
      rr       <= '0;
      att_v    <= 1'b0;
      att_q    <= '0;
      lock_v   <= 1'b0;
      lock_id  <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      ovf_cnt  <= '0;
    end else begin
      att_v <= arm;
      if (arm) att_q <= '{id: slot, cyc: cyc, val: val};
      if (ev_pass) pass_cnt <= sat_inc(pass_cnt);
      if (ev_fail) fail_cnt <= sat_inc(fail_cnt);
      if (ovf_ev)  ovf_cnt  <= sat_inc(ovf_cnt);

      if (acc) begin
        rr     <= (gnt_id == ID_W'(NUM_CHK - 1)) ? '0 : gnt_id + 1'b1;
        lock_v <= 1'b0;
      end else if (fail_valid) begin
        lock_v  <= 1'b1;
        lock_id <= gnt_id;
      end

      case (state)
        S_IDLE, S_DONE: if (start) begin
          state    <= S_RUN;
          cyc      <= '0;
          val      <= 1'b0;
          slot     <= '0;
          rr       <= '0;
          att_v    <= 1'b0;
          lock_v   <= 1'b0;
          pass_cnt <= '0;
          fail_cnt <= '0;
          ovf_cnt  <= '0;
        end
        S_RUN: begin
          cyc  <= cyc + 1'b1;
          val  <= inject_err ? val : ~val;
          slot <= (slot == ID_W'(NUM_CHK - 1)) ? '0 : slot + 1'b1;
          if (cyc == CYC_W'(MAX_CYC)) state <= S_DRAIN;
        end
        S_DRAIN: if (!fail_valid) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prop_check_sched.sv
// Directed scenarios for prop_check_sched, checked every cycle against a history-based model.

module tb_prop_check_sched;
  localparam int N    = 2;
  localparam int MAXC = 11;
  localparam int CW   = 32;
  localparam int KW   = 8;
  localparam int IW   = $clog2(N);
  localparam int SATV = (1 << KW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          inject_err = 1'b0;
  logic          fail_ready = 1'b0;
  logic [N-1:0]  chk_en = '0;
  logic          val, busy, done, fail_valid, stop_req;
  logic [CW-1:0] cyc, fail_cyc;
  logic [IW-1:0] fail_id;
  logic [KW-1:0] pass_cnt, fail_cnt, ovf_cnt;

  int tests = 0;
  int fails = 0;

  prop_check_sched #(.NUM_CHK(N), .MAX_CYC(MAXC), .CYC_W(CW), .CNT_W(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .chk_en(chk_en), .inject_err(inject_err),
    .val(val), .cyc(cyc), .busy(busy), .done(done), .fail_valid(fail_valid),
    .fail_ready(fail_ready), .fail_id(fail_id), .fail_cyc(fail_cyc),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .ovf_cnt(ovf_cnt), .stop_req(stop_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: val history per cycle, pending report per check ----------------
  int  m_st;   // 0 idle, 1 run, 2 drain, 3 done
  int  m_cyc, m_pass, m_fail, m_ovf, m_rr, m_hid, m_aid, m_acyc;
  bit  m_val, m_held, m_av;
  bit  m_flag[N];
  int  m_fcyc[N];
  bit  m_vh[0:31];

  function automatic bit m_any();
    for (int i = 0; i < N; i++) if (m_flag[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_grant();
    if (m_held) return m_hid;
    for (int i = 0; i < N; i++) if (m_flag[(m_rr + i) % N]) return (m_rr + i) % N;
    return 0;
  endfunction

  function automatic int sat(input int v);
    return (v > SATV) ? SATV : v;
  endfunction

  task automatic model_step();
    bit fv, acc, evf;
    int gid;
    logic [IW-1:0] ix;
    if (rst) begin
      m_st = 0; m_cyc = 0; m_val = 0; m_pass = 0; m_fail = 0; m_ovf = 0;
      m_rr = 0; m_held = 0; m_av = 0;
      for (int i = 0; i < N; i++) begin m_flag[i] = 0; m_fcyc[i] = 0; end
      return;
    end
    fv  = m_any();
    gid = m_grant();
    acc = fv && fail_ready;
    evf = 0;
    if (m_av) begin
      if (m_vh[m_acyc + 1] != m_vh[m_acyc]) m_pass = sat(m_pass + 1);
      else begin evf = 1; m_fail = sat(m_fail + 1); end
    end
    m_av = 0;
    if (acc) begin m_flag[gid] = 0; m_rr = (gid + 1) % N; m_held = 0; end
    else if (fv) begin m_held = 1; m_hid = gid; end
    if (evf) begin
      if (m_flag[m_aid]) m_ovf = sat(m_ovf + 1);
      else begin m_flag[m_aid] = 1; m_fcyc[m_aid] = m_acyc; end
    end
    case (m_st)
      0, 3: if (start) begin
        m_st = 1; m_cyc = 0; m_val = 0; m_vh[0] = 0;
        m_pass = 0; m_fail = 0; m_ovf = 0; m_rr = 0; m_held = 0; m_av = 0;
        for (int i = 0; i < N; i++) m_flag[i] = 0;
      end
      1: begin
        ix = IW'(m_cyc % N);
        if (m_cyc < MAXC && chk_en[ix]) begin m_av = 1; m_aid = m_cyc % N; m_acyc = m_cyc; end
        if (m_cyc == MAXC) m_st = 2;
        if (!inject_err) m_val = !m_val;
        m_cyc++;
        m_vh[m_cyc] = m_val;
      end
      2: if (!fv) m_st = 3;
      default: ;
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- compare process + accepted-report log ----------------
  int r_id[$];
  int r_cyc[$];
  int r_t[$];
  int seen_fv = 0;
  int tick = 0;

  initial begin
    logic pv, pr, prst;
    logic [IW-1:0] pid;
    logic [CW-1:0] pc;
    pv = 0; pr = 0; prst = 1; pid = '0; pc = '0;
    forever begin
      @(negedge clk); #3;
      chk("val", val, m_val);
      chk("cyc", cyc, m_cyc);
      chk("busy", busy, (m_st == 1 || m_st == 2));
      chk("done", done, (m_st == 3));
      chk("fail_valid", fail_valid, m_any());
      chk("pass_cnt", pass_cnt, m_pass);
      chk("fail_cnt", fail_cnt, m_fail);
      chk("ovf_cnt", ovf_cnt, m_ovf);
      chk("stop_req", stop_req, (m_st == 3 && m_fail != 0));
      if (fail_valid === 1'b1) begin
        chk("fail_id", fail_id, m_grant());
        chk("fail_cyc", fail_cyc, m_fcyc[m_grant()]);
        seen_fv++;
      end
      if (pv && !pr && !prst) begin
        chk("hold_valid", fail_valid, 1);
        chk("hold_id", fail_id, pid);
        chk("hold_cyc", fail_cyc, pc);
      end
      if (fail_valid === 1'b1 && fail_ready) begin
        r_id.push_back(int'(fail_id));
        r_cyc.push_back(int'(fail_cyc));
        r_t.push_back(tick);
      end
      pv = fail_valid; pr = fail_ready; prst = rst; pid = fail_id; pc = fail_cyc;
      tick++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  task automatic drv();
    @(negedge clk); #1;
  endtask

  task automatic run_scn(input logic [N-1:0] en, input int inj_mask, input int rdy_from,
                         input int rst_at);
    bit ended;
    r_id.delete(); r_cyc.delete(); r_t.delete(); seen_fv = 0;
    drv();
    chk_en = en; start = 1; inject_err = 0; fail_ready = (rdy_from <= 0);
    drv();
    start = 0;
    ended = 0;
    for (int n = 0; n < 100; n++) begin
      inject_err = (n <= MAXC) ? (((inj_mask >> n) & 1) != 0) : 1'b0;
      fail_ready = (n >= rdy_from);
      rst = (n == rst_at);
      if (done === 1'b1 || (rst_at >= 0 && n == rst_at + 1)) begin ended = 1; break; end
      drv();
    end
    inject_err = 0;
    rst = 0;
    if (!ended) chk("timeout", 0, 1);
  endtask

  task automatic check_s1(input string tag);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_pass"}, pass_cnt, 11);
    chk({tag, "_fail"}, fail_cnt, 0);
    chk({tag, "_stop"}, stop_req, 0);
    chk({tag, "_nrep"}, r_id.size(), 0);
  endtask

  initial begin
    drv(); drv();
    chk("rst_busy", busy, 0);
    chk("rst_val", val, 0);
    chk("rst_cyc", cyc, 0);
    chk("rst_valid", fail_valid, 0);
    chk("rst_pass", pass_cnt, 0);
    rst = 0;

    // 1: all checks enabled, clean toggling
    run_scn(2'b11, 0, 0, -1);
    check_s1("s1");

    // 2: only even slots
    run_scn(2'b01, 0, 0, -1);
    chk("s2_pass", pass_cnt, 6);
    chk("s2_fail", fail_cnt, 0);
    chk("s2_seen_fv", seen_fv, 0);

    // 3: single injected hold at cyc 4
    run_scn(2'b11, 1 << 4, 0, -1);
    chk("s3_pass", pass_cnt, 10);
    chk("s3_fail", fail_cnt, 1);
    chk("s3_stop", stop_req, 1);
    chk("s3_nrep", r_id.size(), 1);
    if (r_id.size() == 1) begin
      chk("s3_id", r_id[0], 0);
      chk("s3_cyc", r_cyc[0], 4);
    end

    // 4: stalled reporter, second failure on same check is dropped
    run_scn(2'b11, (1 << 4) | (1 << 6), 12, -1);
    chk("s4_fail", fail_cnt, 2);
    chk("s4_ovf", ovf_cnt, 1);
    chk("s4_pass", pass_cnt, 9);
    chk("s4_nrep", r_id.size(), 1);
    if (r_id.size() == 1) begin
      chk("s4_id", r_id[0], 0);
      chk("s4_cyc", r_cyc[0], 4);
    end

    // 5: two checks pending, drained in round-robin order on consecutive cycles
    run_scn(2'b11, (1 << 4) | (1 << 5), 12, -1);
    chk("s5_fail", fail_cnt, 2);
    chk("s5_ovf", ovf_cnt, 0);
    chk("s5_nrep", r_id.size(), 2);
    if (r_id.size() == 2) begin
      chk("s5_id0", r_id[0], 0);
      chk("s5_cyc0", r_cyc[0], 4);
      chk("s5_id1", r_id[1], 1);
      chk("s5_cyc1", r_cyc[1], 5);
      chk("s5_consec", r_t[1] - r_t[0], 1);
    end

    // 7: new failure on the check being accepted re-arms it without overflow
    run_scn(2'b11, (1 << 4) | (1 << 6), 7, -1);
    chk("s7_ovf", ovf_cnt, 0);
    chk("s7_fail", fail_cnt, 2);
    chk("s7_nrep", r_id.size(), 2);
    if (r_id.size() == 2) begin
      chk("s7_cyc0", r_cyc[0], 4);
      chk("s7_id1", r_id[1], 0);
      chk("s7_cyc1", r_cyc[1], 6);
    end

    // 6: reset mid-run with a report outstanding, then a clean rerun
    run_scn(2'b11, 1 << 4, 99, 6);
    chk("s6_busy", busy, 0);
    chk("s6_done", done, 0);
    chk("s6_valid", fail_valid, 0);
    chk("s6_cyc", cyc, 0);
    chk("s6_val", val, 0);
    chk("s6_fail", fail_cnt, 0);
    run_scn(2'b11, 0, 0, -1);
    check_s1("s6r");

    drv(); drv();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
